// File: rtl/serial_paralelo_ctrl.sv
// serial_paralelo_ctrl
// Receive-side link controller for the clk_4f byte stream coming out of
// serial_paralelo1. It acquires lock on a run of comma characters, drops
// lock on a run of bad symbols or loss of converter alignment, strips
// commas, and forwards payload bytes one cycle after they are sampled.
// A saturating counter tracks bad symbols seen while locked.
//
// Ports:
//   clk_4f       byte clock, one byte per rising edge
//   reset        synchronous active-high reset
//   data_rx000   recovered byte from the converter
//   valid_rx000  converter marks the byte as valid payload
//   active       converter comma alignment achieved
//   clear_err    single-cycle strobe clearing err_count
//   data_out_p   forwarded payload byte (holds between payload bytes)
//   valid_out    data_out_p carries a new payload byte this cycle
//   link_up      controller is LOCKED
//   realign      one-cycle pulse asking the converter to re-hunt
//   state        FSM state: RESET=0, HUNT=1, LOCKED=2, LOST=3
//   err_count    saturating bad-symbol count
module serial_paralelo_ctrl #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         LOSS_COUNT = 3
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_rx000,
  input  logic       valid_rx000,
  input  logic       active,
  input  logic       clear_err,
  output logic [7:0] data_out_p,
  output logic       valid_out,
  output logic       link_up,
  output logic       realign,
  output logic [1:0] state,
  output logic [7:0] err_count
);

  localparam int CW = $clog2(SYNC_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2,
    S_LOST   = 2'd3
  } state_e;

  state_e        state_q;
  logic [CW-1:0] comma_run_q;
  logic [LW-1:0] bad_run_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          link_q;
  logic          realign_q;
  logic [7:0]    err_count_q;
  logic [7:0]    err_count_d;

  logic is_comma;
  logic is_good;
  logic is_bad;
  logic err_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign is_comma = (data_rx000 == COMMA);
  assign is_good  = !is_comma && valid_rx000;
  assign is_bad   = !is_comma && !valid_rx000;

  // Bad bytes only count while locked, including the cycle in which
  // alignment drops out.
  assign err_inc = (state_q == S_LOCKED) && is_bad;

  // Clear takes priority over a simultaneous increment.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = 8'h00;
    end else if (err_inc) begin
      err_count_d = sat_inc8(err_count_q);
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q     <= S_RESET;
      comma_run_q <= '0;
      bad_run_q   <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      link_q      <= 1'b0;
      realign_q   <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      err_count_q <= err_count_d;
      valid_q     <= 1'b0;
      realign_q   <= 1'b0;
      case (state_q)
        S_RESET: begin
          state_q <= S_HUNT;
          link_q  <= 1'b0;
        end
        S_HUNT: begin
          link_q <= 1'b0;
          if (active && is_comma) begin
            if (comma_run_q == CW'(SYNC_COUNT - 1)) begin
              state_q     <= S_LOCKED;
              link_q      <= 1'b1;
              comma_run_q <= '0;
              bad_run_q   <= '0;
            end else begin
              comma_run_q <= comma_run_q + 1'b1;
            end
          end else begin
            comma_run_q <= '0;
          end
        end
        S_LOCKED: begin
          if (!active) begin
            // Alignment gone: leave immediately, never forward this byte.
            state_q   <= S_LOST;
            link_q    <= 1'b0;
            realign_q <= 1'b1;
          end else if (is_good) begin
            data_q    <= data_rx000;
            valid_q   <= 1'b1;
            bad_run_q <= '0;
          end else if (is_comma) begin
            bad_run_q <= '0;
          end else if (bad_run_q == LW'(LOSS_COUNT - 1)) begin
            state_q   <= S_LOST;
            link_q    <= 1'b0;
            realign_q <= 1'b1;
          end else begin
            bad_run_q <= bad_run_q + 1'b1;
          end
        end
        S_LOST: begin
          state_q     <= S_HUNT;
          link_q      <= 1'b0;
          comma_run_q <= '0;
          bad_run_q   <= '0;
        end
        default: begin
          state_q <= S_RESET;
          link_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_p = data_q;
  assign valid_out  = valid_q;
  assign link_up    = link_q;
  assign realign    = realign_q;
  assign state      = state_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_serial_paralelo_ctrl.sv
module tb_serial_paralelo_ctrl;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int SYNC = 4;
  localparam int LOSS = 3;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_rx000 = 8'h00;
  logic       valid_rx000 = 1'b0;
  logic       active = 1'b1;
  logic       clear_err = 1'b0;
  logic [7:0] data_out_p;
  logic       valid_out;
  logic       link_up;
  logic       realign;
  logic [1:0] state;
  logic [7:0] err_count;

  serial_paralelo_ctrl #(.COMMA(COMMA), .SYNC_COUNT(SYNC), .LOSS_COUNT(LOSS)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_rx000(data_rx000),
    .valid_rx000(valid_rx000), .active(active), .clear_err(clear_err),
    .data_out_p(data_out_p), .valid_out(valid_out), .link_up(link_up),
    .realign(realign), .state(state), .err_count(err_count)
  );

  always #5 clk_4f = ~clk_4f;

  int checks = 0;
  int failures = 0;
  bit done = 0;

  // Expected forwarded payload bytes, in order.
  logic [7:0] exp_q[$];

  // Reference model: link mode (0 reset, 1 hunting, 2 locked, 3 lost),
  // count of consecutive commas / bad symbols, and visible outputs.
  int m_mode = 0;
  int m_commas = 0;
  int m_bads = 0;
  int m_err = 0;
  int m_data = 0;
  bit m_valid = 0;
  bit m_realign = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic [7:0] d, input bit v, input bit a,
                       input bit clr, input bit r);
    bit comma, good, bad;
    comma = (d == COMMA);
    good  = !comma && v;
    bad   = !comma && !v;
    if (r) begin
      m_mode = 0; m_commas = 0; m_bads = 0; m_err = 0;
      m_data = 0; m_valid = 0; m_realign = 0;
      return;
    end
    m_valid = 0;
    m_realign = 0;
    if (clr) m_err = 0;
    else if (m_mode == 2 && bad && m_err < 255) m_err = m_err + 1;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (a && comma) begin
          m_commas++;
          if (m_commas == SYNC) begin
            m_mode = 2; m_commas = 0; m_bads = 0;
          end
        end else m_commas = 0;
      end
      2: begin
        if (!a) begin
          m_mode = 3; m_realign = 1;
        end else if (good) begin
          m_data = d; m_valid = 1; m_bads = 0;
          exp_q.push_back(d);
        end else if (comma) begin
          m_bads = 0;
        end else begin
          m_bads++;
          if (m_bads == LOSS) begin
            m_mode = 3; m_realign = 1;
          end
        end
      end
      default: begin
        m_mode = 1; m_commas = 0; m_bads = 0;
      end
    endcase
  endtask

  task automatic step(input logic [7:0] d, input bit v, input bit a,
                      input bit clr, input bit r);
    data_rx000 = d; valid_rx000 = v; active = a; clear_err = clr; reset = r;
    @(posedge clk_4f);
    model(d, v, a, clr, r);
    #1;
    check("state", int'(state), m_mode);
    check("link_up", int'(link_up), (m_mode == 2) ? 1 : 0);
    check("valid_out", int'(valid_out), int'(m_valid));
    check("realign", int'(realign), int'(m_realign));
    check("err_count", int'(err_count), m_err);
    check("data_out_p", int'(data_out_p), m_data);
  endtask

  task automatic comma_b();            step(COMMA, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic good_b(input logic [7:0] d); step(d, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic bad_b();              step(8'h10, 1'b0, 1'b1, 1'b0, 1'b0); endtask

  // One filler byte (covers the LOST cycle) then a full comma run.
  task automatic relock();
    comma_b();
    for (int i = 0; i < SYNC; i++) comma_b();
  endtask

  // Monitor: every presented payload byte must match the next expected one.
  initial begin
    forever begin
      @(negedge clk_4f);
      if (done) break;
      if (valid_out === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL payload_unexpected: got=%0h expected=none", data_out_p);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_out_p !== e) begin
            failures++;
            $display("FAIL payload: got=%0h expected=%0h", data_out_p, e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] rd;
    // Reset, then one cycle for RESET -> HUNT.
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    check("reset_state", int'(state), 0);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("hunt_after_reset", int'(state), 1);

    // Lock then stream 01..05 at full rate.
    for (int i = 0; i < SYNC; i++) comma_b();
    check("locked", int'(link_up), 1);
    for (int i = 1; i <= 5; i++) good_b(8'(i));

    // Back to HUNT via an alignment drop, then a broken comma run.
    step(COMMA, 1'b0, 1'b0, 1'b0, 1'b0);
    comma_b();
    comma_b(); comma_b(); comma_b();
    step(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    comma_b();
    check("no_lock_broken_run", int'(state), 1);
    for (int i = 0; i < SYNC; i++) comma_b();
    check("relocked_err0", int'(err_count), 0);

    // bad,bad,good,bad,bad,bad: five errors, loss on the last.
    bad_b(); bad_b(); good_b(8'h77); bad_b(); bad_b(); bad_b();
    check("lost_after_bads", int'(state), 3);
    check("err_after_bads", int'(err_count), 5);
    comma_b();
    check("hunt_after_lost", int'(state), 1);

    // Interleaved comma is stripped.
    for (int i = 0; i < SYNC; i++) comma_b();
    good_b(8'hAA); comma_b(); good_b(8'hBB);

    // One-cycle alignment drop with a good byte: lost, nothing counted.
    step(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drop_active_lost", int'(state), 3);

    // Drive err_count into saturation over repeated relocks.
    for (int k = 0; k < 100; k++) begin
      relock();
      bad_b(); bad_b(); bad_b();
    end
    check("err_saturated", int'(err_count), 255);

    // clear_err concurrent with a counted bad byte.
    relock();
    step(8'h10, 1'b0, 1'b1, 1'b1, 1'b0);
    check("clear_wins", int'(err_count), 0);

    // Reset mid-payload.
    good_b(8'h5A);
    step(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("midreset_state", int'(state), 0);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      rd = ($urandom_range(0, 2) == 0) ? COMMA : 8'($urandom);
      step(rd, ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) != 0),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
    end

    @(negedge clk_4f);
    #1;
    done = 1;
    check("payload_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
